game_flow_ctrl: RTL and testbench

Top-level sequencer for the 2x2 sliding-puzzle datapath. Drives the puzzle core's game_status, set/random/num board-load strobes and one-hot act move pulses from raw buttons/switches. Consumes the core's registered win_flag. Keeps a shadow blank-tile position so only legal moves are issued, and maintains move and seconds counters for the display path.

---
 rtl/game_flow_ctrl.sv | 130 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: button/switch sequencer for the 2x2 sliding-puzzle core with legal-move filtering and move/seconds counters
module game_flow_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TIME_LIMIT    = 99,
  parameter int MAX_MOVES     = 999,
  parameter int INIT_CYCLES   = 3
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_confirm,
  input  logic       sw_random,
  input  logic [4:0] sw_num,
  input  logic [3:0] btn_dir,
  input  logic       win_flag,
  output logic [1:0] game_status,
  output logic       set,
  output logic       random,
  output logic [4:0] num,
  output logic [3:0] act,
  output logic [9:0] move_cnt,
  output logic [6:0] sec_cnt,
  output logic       timeout
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int IW = $clog2(INIT_CYCLES);
  localparam logic [1:0] LEFT_DOWN = 2'b10;
  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAME_INITIAL = 2'b10,
    GAMING       = 2'b01,
    WINNED       = 2'b11
  } state_t;
  state_t r_state, w_next;
  logic          r_start_q, r_conf_q;
  logic [3:0]    r_dir_q;
  logic          r_loaded;
  logic [1:0]    r_pos;
  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_init;
  logic          r_set, r_random, r_timeout;
  logic [4:0]    r_num;
  logic [3:0]    r_act;
  logic [9:0]    r_moves;
  logic [6:0]    r_sec;
  logic          w_start_rise, w_conf_rise, w_load_ok, w_tick, w_limit;
  logic          w_enter_init, w_stay, w_to_chose;
  logic [3:0]    w_dir_rise, w_dir_sel, w_move;
  logic [1:0]    w_pos_nxt;
  assign w_start_rise = btn_start & ~r_start_q;
  assign w_conf_rise  = btn_confirm & ~r_conf_q;
  assign w_dir_rise   = btn_dir & ~r_dir_q;
  assign w_dir_sel    = w_dir_rise & (~w_dir_rise + 4'd1);
  // r_pos = {row_down, col_right}; mask keeps only moves that stay inside the 2x2 grid
  assign w_move       = w_dir_sel & {r_pos[0], ~r_pos[1], ~r_pos[0], r_pos[1]};
  assign w_pos_nxt    = {w_move[2] | (r_pos[1] & ~w_move[0]), w_move[1] | (r_pos[0] & ~w_move[3])};
  assign w_load_ok    = (r_state == CHOSE_BOARD) && w_conf_rise && (sw_random || sw_num <= 5'd23);
  assign w_tick       = r_pre == PW'(TICKS_PER_SEC - 1);
  assign w_limit      = r_sec == 7'(TIME_LIMIT);
  assign w_enter_init = (r_state == CHOSE_BOARD) && (w_next == GAME_INITIAL);
  assign w_stay       = (r_state == GAMING) && (w_next == GAMING);
  assign w_to_chose   = (r_state != CHOSE_BOARD) && (w_next == CHOSE_BOARD);
  assign game_status  = r_state;
  assign set          = r_set;
  assign random       = r_random;
  assign num          = r_num;
  assign act          = r_act;
  assign move_cnt     = r_moves;
  assign sec_cnt      = r_sec;
  assign timeout      = r_timeout;
  // state register
  always_ff @(posedge clk_d or posedge rst)
    if (rst) r_state <= CHOSE_BOARD;
    else     r_state <= w_next;
  // next state; in GAMING a win outranks the time limit, which outranks an abort
  always_comb begin
    w_next = r_state;
    case (r_state)
      CHOSE_BOARD:  w_next = (w_start_rise && r_loaded) ? GAME_INITIAL : CHOSE_BOARD;
      GAME_INITIAL: w_next = (r_init == IW'(INIT_CYCLES - 1)) ? GAMING : GAME_INITIAL;
      GAMING:       w_next = (win_flag || w_limit) ? WINNED : (w_start_rise ? CHOSE_BOARD : GAMING);
      default:      w_next = w_start_rise ? CHOSE_BOARD : WINNED;
    endcase
  end
  // edge history, board-load strobe, move pulses, shadow blank position and game counters
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_conf_q  <= 1'b0;
      r_dir_q   <= 4'd0;
      r_set     <= 1'b0;
      r_random  <= 1'b0;
      r_num     <= 5'd0;
      r_act     <= 4'd0;
      r_loaded  <= 1'b0;
      r_init    <= '0;
      r_pre     <= '0;
      r_sec     <= 7'd0;
      r_moves   <= 10'd0;
      r_timeout <= 1'b0;
      r_pos     <= LEFT_DOWN;
    end else begin
      r_start_q <= btn_start;
      r_conf_q  <= btn_confirm;
      r_dir_q   <= btn_dir;
      r_set     <= w_load_ok;
      r_act     <= w_stay ? w_move : 4'd0;
      r_init    <= (r_state == GAME_INITIAL) ? r_init + 1'b1 : '0;
      r_loaded  <= w_to_chose ? 1'b0 : (r_loaded | w_load_ok);
      if (w_load_ok) begin
        r_random <= sw_random;
        r_num    <= sw_num;
      end
      if (w_enter_init) begin
        r_pre     <= '0;
        r_sec     <= 7'd0;
        r_moves   <= 10'd0;
        r_timeout <= 1'b0;
        r_pos     <= LEFT_DOWN;
      end else if (w_stay) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        r_sec <= r_sec + {6'd0, w_tick};
        r_pos <= w_pos_nxt;
        if (|w_move && r_moves != 10'(MAX_MOVES)) r_moves <= r_moves + 10'd1;
      end else if (r_state == GAMING && !win_flag && w_limit) begin
        r_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed and random stimulus against a grid-level reference model with a queued output scoreboard
module tb_game_flow_ctrl;
  localparam int TICKS = 4;
  localparam int LIMIT = 3;
  localparam int MAXMV = 4;
  localparam int INITC = 3;
  localparam int M_CHOOSE = 0, M_INIT = 1, M_PLAY = 2, M_WON = 3;
  typedef struct packed {
    logic [1:0] st;
    logic       set;
    logic       rnd;
    logic [4:0] num;
    logic [3:0] act;
    logic [9:0] mv;
    logic [6:0] sec;
    logic       to;
  } snap_t;
  logic       clk_d = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_confirm = 1'b0, sw_random = 1'b0, win_flag = 1'b0;
  logic [4:0] sw_num = 5'd0;
  logic [3:0] btn_dir = 4'd0;
  logic [1:0] t_status;
  logic       t_set, t_random, t_timeout;
  logic [4:0] t_num;
  logic [3:0] t_act;
  logic [9:0] t_move;
  logic [6:0] t_sec;
  int checks = 0, errors = 0, cyc_no = 0;
  bit mon_en = 0;
  snap_t exp_q[$];
  int m_mode, m_init_left, m_row, m_col, m_moves, m_ticks, m_sec, m_num, m_act;
  bit m_loaded, m_timeout, m_set, m_random, p_start, p_conf;
  bit [3:0] p_dir;
  int dr[4] = '{-1, 0, 1, 0};
  int dc[4] = '{0, 1, 0, -1};

  game_flow_ctrl #(.TICKS_PER_SEC(TICKS), .TIME_LIMIT(LIMIT), .MAX_MOVES(MAXMV), .INIT_CYCLES(INITC)) dut (
    .clk_d(clk_d), .rst(rst), .btn_start(btn_start), .btn_confirm(btn_confirm),
    .sw_random(sw_random), .sw_num(sw_num), .btn_dir(btn_dir), .win_flag(win_flag),
    .game_status(t_status), .set(t_set), .random(t_random), .num(t_num), .act(t_act),
    .move_cnt(t_move), .sec_cnt(t_sec), .timeout(t_timeout)
  );

  always #5 clk_d = ~clk_d;

  task automatic model_reset();
    m_mode = M_CHOOSE; m_loaded = 0; m_init_left = 0; m_row = 1; m_col = 0;
    m_moves = 0; m_ticks = 0; m_sec = 0; m_timeout = 0; m_set = 0; m_random = 0;
    m_num = 0; m_act = 0; p_start = 0; p_conf = 0; p_dir = 4'd0;
  endtask

  task automatic model_step();
    bit s_r, c_r, was;
    bit [3:0] d_r;
    int nr, nc;
    if (rst) begin
      model_reset();
      return;
    end
    s_r = btn_start && !p_start;
    c_r = btn_confirm && !p_conf;
    d_r = btn_dir & ~p_dir;
    p_start = btn_start; p_conf = btn_confirm; p_dir = btn_dir;
    m_set = 0; m_act = 0;
    case (m_mode)
      M_CHOOSE: begin
        was = m_loaded;
        if (c_r && (sw_random || sw_num < 24)) begin
          m_set = 1; m_random = sw_random; m_num = int'(sw_num); m_loaded = 1;
        end
        if (s_r && was) begin
          m_mode = M_INIT; m_init_left = INITC; m_moves = 0; m_sec = 0; m_ticks = 0;
          m_timeout = 0; m_row = 1; m_col = 0;
        end
      end
      M_INIT: begin
        m_init_left--;
        if (m_init_left == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (win_flag) m_mode = M_WON;
        else if (m_sec == LIMIT) begin m_timeout = 1; m_mode = M_WON; end
        else if (s_r) begin m_mode = M_CHOOSE; m_loaded = 0; end
        else begin
          for (int d = 0; d < 4; d++) if (d_r[d]) begin
            nr = m_row + dr[d];
            nc = m_col + dc[d];
            if (nr >= 0 && nr <= 1 && nc >= 0 && nc <= 1) begin
              m_row = nr; m_col = nc; m_act = 1 << d;
              m_moves = (m_moves + 1 > MAXMV) ? MAXMV : m_moves + 1;
            end
            break;
          end
          m_ticks++;
          if (m_ticks == TICKS) begin m_ticks = 0; m_sec++; end
        end
      end
      default: if (s_r) begin m_mode = M_CHOOSE; m_loaded = 0; end
    endcase
  endtask

  function automatic snap_t mk_snap();
    snap_t s;
    s.st  = (m_mode == M_CHOOSE) ? 2'b00 : (m_mode == M_INIT) ? 2'b10 : (m_mode == M_PLAY) ? 2'b01 : 2'b11;
    s.set = m_set; s.rnd = m_random; s.num = 5'(m_num); s.act = 4'(m_act);
    s.mv = 10'(m_moves); s.sec = 7'(m_sec); s.to = m_timeout;
    return s;
  endfunction

  task automatic tick();
    model_step();
    exp_q.push_back(mk_snap());
    @(negedge clk_d);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start();
    btn_start = 1; tick(); btn_start = 0; tick();
  endtask

  task automatic press_confirm(input bit rnd, input int idx);
    sw_random = rnd; sw_num = 5'(idx); btn_confirm = 1; tick(); btn_confirm = 0; tick();
  endtask

  task automatic press_dir(input bit [3:0] d);
    btn_dir = d; tick(); btn_dir = 4'd0; tick();
  endtask

  task automatic async_reset();
    model_reset();
    exp_q.push_back(mk_snap());
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic wait_mode(input int mode, input string what);
    int n = 0;
    while (m_mode != mode && n < 100) begin tick(); n++; end
    checks++;
    if (m_mode != mode) begin
      errors++;
      $display("FAIL wait_%s: model mode %0d, required %0d within 100 cycles", what, m_mode, mode);
    end
  endtask

  task automatic new_game(input bit rnd, input int idx);
    press_confirm(rnd, idx);
    press_start();
    wait_mode(M_PLAY, "gaming");
  endtask

  // scoreboard monitor: one expected snapshot per clock edge or asynchronous reset
  initial begin
    snap_t e, g;
    wait (mon_en);
    forever begin
      @(posedge clk_d or posedge rst);
      #1;
      cyc_no++;
      g = {t_status, t_set, t_random, t_num, t_act, t_move, t_sec, t_timeout};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: cycle %0d output with no expected entry", cyc_no);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got st=%b set=%b rnd=%b num=%0d act=%b mv=%0d sec=%0d to=%b, expected st=%b set=%b rnd=%b num=%0d act=%b mv=%0d sec=%0d to=%b",
                   cyc_no, g.st, g.set, g.rnd, g.num, g.act, g.mv, g.sec, g.to,
                   e.st, e.set, e.rnd, e.num, e.act, e.mv, e.sec, e.to);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_d);
    rst = 0;
    model_reset();
    mon_en = 1;
    ticks(2);
    press_start();
    press_confirm(0, 5);
    press_confirm(0, 24);
    ticks(1);
    press_start();
    wait_mode(M_PLAY, "gaming");
    press_dir(4'b1000);
    press_dir(4'b0001);
    press_dir(4'b0100);
    press_dir(4'b0011);
    win_flag = 1; tick(); win_flag = 0;
    ticks(3);
    press_start();
    press_start();
    ticks(2);
    new_game(1, 30);
    ticks(16);
    press_start();
    new_game(0, 23);
    for (int n = 0; n < 100 && !(m_mode == M_PLAY && m_sec == LIMIT); n++) tick();
    win_flag = 1; tick(); win_flag = 0;
    ticks(2);
    press_start();
    new_game(0, 0);
    press_dir(4'b0001); press_dir(4'b0100); press_dir(4'b0001); press_dir(4'b0100); press_dir(4'b0010);
    press_start();
    new_game(0, 7);
    press_dir(4'b0010);
    async_reset();
    ticks(2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else begin
        btn_start   = ($urandom_range(0, 15) == 0);
        btn_confirm = ($urandom_range(0, 5) == 0);
        sw_random   = 1'($urandom);
        sw_num      = 5'($urandom);
        btn_dir     = 4'($urandom) & 4'($urandom);
        win_flag    = ($urandom_range(0, 47) == 0);
        tick();
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
